pipeline_ctrl: RTL and testbench

Sequential pipeline sequencer. It consumes the stall and flush requests from hazard detection and the redirect, memory-busy and halt events, and drives PC and per-stage pipeline-register enables and valid bits for the 5-stage RISC-V core (IF/ID, ID/EX, EX/MEM, MEM/WB). It owns bubble insertion, whole-pipe freeze for multi-cycle memory, and halt draining, and reports per-cycle commit.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_perf_counters.sv | 31 +++
 rtl/pipeline_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    StBoot,
    StRun,
    StFreeze,
    StDrain,
    StHalted
  } pipe_state_e;

  localparam int unsigned NUM_STAGES  = 4;
  localparam int unsigned STG_IF_ID  = 0;
  localparam int unsigned STG_ID_EX  = 1;
  localparam int unsigned STG_EX_MEM = 2;
  localparam int unsigned STG_MEM_WB = 3;

endpackage

// File: rtl/pipe_perf_counters.sv
// Free-running pipeline performance counters; each wraps modulo 2^CNT_W.
module pipe_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cycle_inc,
  input  logic             retire_inc,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      if (cycle_inc)  cycle_cnt  <= cycle_cnt + CNT_W'(1);
      if (retire_inc) retire_cnt <= retire_cnt + CNT_W'(1);
      if (stall_inc)  stall_cnt  <= stall_cnt + CNT_W'(1);
      if (flush_inc)  flush_cnt  <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/valids, freeze, flush, stall and halt drain.
// Perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_STALL_MAX = 64,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ready,
  input  logic             stall_req,
  input  logic             if_id_flush_req,
  input  logic             id_ex_flush_req,
  input  logic             redirect,
  input  logic             dmem_busy,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_valid,
  output logic             id_ex_valid,
  output logic             ex_mem_valid,
  output logic             mem_wb_valid,
  output logic             wb_commit,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned BcW = $clog2(MEM_STALL_MAX + 1);

  pipe_state_e           state_q, state_d, ret_q, ret_d;
  logic [BcW-1:0]        busy_cnt_q, busy_cnt_d;
  logic                  halt_q, timeout_q, timeout_d, halted_q;
  logic [NUM_STAGES-1:0] valid_q, valid_d, en;
  logic                  active, freeze, adv, stall, flush_any, halt_pend;

  always_comb begin
    active    = (state_q == StRun) || (state_q == StDrain) || (state_q == StFreeze);
    freeze    = active && dmem_busy;
    adv       = active && !dmem_busy;
    halt_pend = halt_req || halt_q;
    flush_any = if_id_flush_req || id_ex_flush_req || redirect;
    stall     = adv && stall_req && !flush_any;

    en      = '0;
    pc_en   = 1'b0;
    pc_sel  = 1'b0;
    valid_d = valid_q;
    if (freeze) begin
      // The WB instruction retired on entry; drop it so it cannot commit twice.
      valid_d[STG_MEM_WB] = 1'b0;
    end else if (adv) begin
      en[STG_ID_EX]       = 1'b1;
      en[STG_EX_MEM]      = 1'b1;
      en[STG_MEM_WB]      = 1'b1;
      valid_d[STG_MEM_WB] = valid_q[STG_EX_MEM];
      valid_d[STG_EX_MEM] = valid_q[STG_ID_EX];
      if (stall) begin
        valid_d[STG_ID_EX] = 1'b0;
      end else begin
        en[STG_IF_ID]      = 1'b1;
        pc_sel             = redirect;
        pc_en              = !halt_pend && (redirect || imem_ready);
        valid_d[STG_ID_EX] = valid_q[STG_IF_ID] && !id_ex_flush_req;
        valid_d[STG_IF_ID] = imem_ready && !halt_pend && !if_id_flush_req;
      end
    end

    state_d    = state_q;
    ret_d      = ret_q;
    busy_cnt_d = busy_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      StBoot: state_d = StRun;
      StRun, StDrain: begin
        if (dmem_busy) begin
          ret_d      = state_q;
          busy_cnt_d = BcW'(1);
          if (MEM_STALL_MAX <= 1) begin
            timeout_d = 1'b1;
            state_d   = StHalted;
          end else begin
            state_d = StFreeze;
          end
        end else if (state_q == StRun && halt_pend) begin
          state_d = StDrain;
        end else if (state_q == StDrain && valid_q == '0) begin
          state_d = StHalted;
        end
      end
      StFreeze: begin
        if (dmem_busy) begin
          busy_cnt_d = busy_cnt_q + BcW'(1);
          if (busy_cnt_d == BcW'(MEM_STALL_MAX)) begin
            timeout_d = 1'b1;
            state_d   = StHalted;
          end
        end else begin
          busy_cnt_d = '0;
          state_d    = halt_pend ? StDrain : ret_q;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StBoot;
    endcase
    if (state_d == StHalted) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      ret_q      <= StRun;
      busy_cnt_q <= '0;
      halt_q     <= 1'b0;
      timeout_q  <= 1'b0;
      halted_q   <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      busy_cnt_q <= busy_cnt_d;
      halt_q     <= halt_pend;
      timeout_q  <= timeout_d;
      halted_q   <= (state_d == StHalted);
      valid_q    <= valid_d;
    end
  end

  assign if_id_en     = en[STG_IF_ID];
  assign id_ex_en     = en[STG_ID_EX];
  assign ex_mem_en    = en[STG_EX_MEM];
  assign mem_wb_en    = en[STG_MEM_WB];
  assign if_id_valid  = valid_q[STG_IF_ID];
  assign id_ex_valid  = valid_q[STG_ID_EX];
  assign ex_mem_valid = valid_q[STG_EX_MEM];
  assign mem_wb_valid = valid_q[STG_MEM_WB];
  assign wb_commit    = valid_q[STG_MEM_WB] && (state_q != StFreeze);
  assign halted       = halted_q;
  assign mem_timeout  = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .cycle_inc (state_q != StHalted),
    .retire_inc(wb_commit),
    .stall_inc (stall || freeze),
    .flush_inc (adv && redirect),
    .cycle_cnt (cycle_cnt),
    .retire_cnt(retire_cnt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed table-driven bench for pipeline_ctrl (MEM_STALL_MAX=4).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ready, stall_req, if_id_flush_req, id_ex_flush_req;
  logic        redirect, dmem_busy, halt_req;
  logic        pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid;
  logic        wb_commit, halted, mem_timeout;
  logic [31:0] cycle_cnt, retire_cnt, stall_cnt, flush_cnt;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .MEM_STALL_MAX(4),
    .CNT_W        (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_ready     (imem_ready),
    .stall_req      (stall_req),
    .if_id_flush_req(if_id_flush_req),
    .id_ex_flush_req(id_ex_flush_req),
    .redirect       (redirect),
    .dmem_busy      (dmem_busy),
    .halt_req       (halt_req),
    .pc_en          (pc_en),
    .pc_sel         (pc_sel),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_en      (mem_wb_en),
    .if_id_valid    (if_id_valid),
    .id_ex_valid    (id_ex_valid),
    .ex_mem_valid   (ex_mem_valid),
    .mem_wb_valid   (mem_wb_valid),
    .wb_commit      (wb_commit),
    .halted         (halted),
    .mem_timeout    (mem_timeout),
    .cycle_cnt      (cycle_cnt),
    .retire_cnt     (retire_cnt),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  // in  = {imem_ready, stall_req, if_id_flush, id_ex_flush, redirect, dmem_busy, halt_req}
  // exp = {pc_en, pc_sel, en[if,id,ex,mem], valid[if,id,ex,mem], wb_commit, halted, mem_timeout}
  typedef struct {
    logic [6:0]  in;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[24];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [12:0] outs();
    return {pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid,
            wb_commit, halted, mem_timeout};
  endfunction

  function automatic logic [31:0] ecnt(input int unsigned v);
    return PerfEn ? 32'(v) : 32'd0;
  endfunction

  task automatic drive(input logic [6:0] v);
    {imem_ready, stall_req, if_id_flush_req, id_ex_flush_req, redirect, dmem_busy, halt_req} = v;
  endtask

  task automatic chk_outs(input string name, input logic [12:0] exp);
    logic [12:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string name, input logic [6:0] in, input logic [12:0] exp);
    drive(in);
    #1;
    chk_outs(name, exp);
    step();
  endtask

  task automatic idle(input int n);
    drive(7'b1000000);
    repeat (n) step();
  endtask

  initial begin
    tbl[0]  = '{7'b1000000, 13'b0_0_0000_0000_000};  // BOOT: no fetch
    tbl[1]  = '{7'b1000000, 13'b1_0_1111_0000_000};
    tbl[2]  = '{7'b1000000, 13'b1_0_1111_1000_000};
    tbl[3]  = '{7'b1000000, 13'b1_0_1111_1100_000};
    tbl[4]  = '{7'b1000000, 13'b1_0_1111_1110_000};
    tbl[5]  = '{7'b1000000, 13'b1_0_1111_1111_100};  // first commit
    tbl[6]  = '{7'b1100000, 13'b0_0_0111_1111_100};  // load-use stall
    tbl[7]  = '{7'b1000000, 13'b1_0_1111_1011_100};
    tbl[8]  = '{7'b1000000, 13'b1_0_1111_1101_100};
    tbl[9]  = '{7'b1000000, 13'b1_0_1111_1110_000};  // bubble reaches WB
    tbl[10] = '{7'b0111100, 13'b1_1_1111_1111_100};  // redirect+flushes beat stall
    tbl[11] = '{7'b1000000, 13'b1_0_1111_0011_100};
    tbl[12] = '{7'b1000000, 13'b1_0_1111_1001_100};
    tbl[13] = '{7'b0000000, 13'b0_0_1111_1100_000};  // no fetch data
    tbl[14] = '{7'b1000000, 13'b1_0_1111_0110_000};
    tbl[15] = '{7'b1000000, 13'b1_0_1111_1011_100};
    tbl[16] = '{7'b1000000, 13'b1_0_1111_1101_100};
    tbl[17] = '{7'b1000000, 13'b1_0_1111_1110_000};
    tbl[18] = '{7'b1000000, 13'b1_0_1111_1111_100};
    tbl[19] = '{7'b1000010, 13'b0_0_0000_1111_100};  // freeze entry, WB retires
    tbl[20] = '{7'b1000110, 13'b0_0_0000_1110_000};  // redirect ignored while frozen
    tbl[21] = '{7'b1000010, 13'b0_0_0000_1110_000};
    tbl[22] = '{7'b1000000, 13'b1_0_1111_1110_000};  // busy fell: advance
    tbl[23] = '{7'b1000000, 13'b1_0_1111_1111_100};

    rst_n = 1'b1;
    drive(7'b0000000);
    #1 rst_n = 1'b0;
    step();
    step();
    drive(7'b1000000);
    #1;
    chk_outs("reset", 13'b0);
    chk_cnt("reset_cycle_cnt", cycle_cnt, 32'd0);
    chk_cnt("reset_retire_cnt", retire_cnt, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) cyc($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);

    chk_cnt("cycle_cnt", cycle_cnt, ecnt(24));
    chk_cnt("retire_cnt", retire_cnt, ecnt(12));
    chk_cnt("stall_cnt", stall_cnt, ecnt(4));
    chk_cnt("flush_cnt", flush_cnt, ecnt(1));

    // Halt drain from a full pipe.
    cyc("halt0", 7'b1000001, 13'b0_0_1111_1111_100);
    cyc("halt1", 7'b1000000, 13'b0_0_1111_0111_100);
    cyc("halt2", 7'b1000000, 13'b0_0_1111_0011_100);
    cyc("halt3", 7'b1000000, 13'b0_0_1111_0001_100);
    cyc("halt4", 7'b1000000, 13'b0_0_1111_0000_000);
    cyc("halted0", 7'b1100000, 13'b0_0_0000_0000_010);
    cyc("halted1", 7'b1000100, 13'b0_0_0000_0000_010);
    chk_cnt("halt_cycle_cnt", cycle_cnt, ecnt(29));
    chk_cnt("halt_retire_cnt", retire_cnt, ecnt(16));

    // Async reset in the middle of a drain.
    drive(7'b1000000);
    rst_n = 1'b0;
    #1;
    chk_outs("reset2", 13'b0);
    rst_n = 1'b1;
    idle(5);
    cyc("drain_h", 7'b1000001, 13'b0_0_1111_1111_100);
    drive(7'b1000000);
    #1;
    chk_outs("drain_mid", 13'b0_0_1111_0111_100);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 13'b0);
    chk_cnt("async_rst_cycle_cnt", cycle_cnt, 32'd0);
    step();
    rst_n = 1'b1;

    // Memory timeout after 4 consecutive busy cycles.
    idle(5);
    cyc("busy1", 7'b1000010, 13'b0_0_0000_1111_100);
    cyc("busy2", 7'b1000010, 13'b0_0_0000_1110_000);
    cyc("busy3", 7'b1000010, 13'b0_0_0000_1110_000);
    cyc("busy4", 7'b1000010, 13'b0_0_0000_1110_000);
    cyc("timeout0", 7'b1000000, 13'b0_0_0000_0000_011);
    cyc("timeout1", 7'b1100100, 13'b0_0_0000_0000_011);
    drive(7'b1000000);
    rst_n = 1'b0;
    #1;
    chk_outs("timeout_reset", 13'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
